// File: rtl/seg7_pkg.sv
// Shared 7-segment types, segment constants and the BCD glyph table.
// Segments are active-low, ordered gfedcba.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_OFF  = 7'h7F;
    localparam seg7_t SEG_DASH = 7'h3F;

    // Nibbles 10..15 are not BCD and render as a dash.
    function automatic seg7_t seg7_of(input logic [3:0] d);
        seg7_t s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to 7-segment glyph decoder.
// Output is active-low gfedcba.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    // Pure table lookup.
    always_comb begin
        seg = seg7_of(nibble);
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 7-segment scanner for a packed-BCD value.
// Double-buffered: new data becomes visible only at a frame boundary.
module bcd_display_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int SCAN_DIV    = 50000,
    parameter int BLANK_ZEROS = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  neg_in,
    output logic [DIGITS-1:0]     digit_sel,
    output seg7_t                 seg,
    output logic                  neg_led,
    output logic                  frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [PW-1:0] LAST_CNT = PW'(SCAN_DIV - 1);
    localparam logic [DIGITS-1:0] ONE_HOT0 = DIGITS'(1);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   shadow;
    logic                  shadow_neg;
    logic                  pending;
    logic [4*DIGITS-1:0]   active;
    logic                  active_neg;

    logic                  tick;
    logic                  wrap;
    logic [IW-1:0]         msd;
    logic [IW-1:0]         msd_p1;
    logic                  nonzero;
    logic                  neg_show;
    logic                  show_dash;
    logic [3:0]            cur_nib;
    seg7_t                 dec_seg;
    seg7_t                 seg_next;

    assign tick = (presc == LAST_CNT);
    assign wrap = tick && (idx == LAST_IDX);

    // Prescaler: one tick every SCAN_DIV cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Digit index advances on each tick and wraps after the last digit.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx <= '0;
        end else if (tick) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
        end
    end

    // Shadow/active double buffer; a load in the wrap cycle lands in
    // shadow while active takes the older pending value.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow     <= '0;
            shadow_neg <= 1'b0;
            pending    <= 1'b0;
            active     <= '0;
            active_neg <= 1'b0;
        end else begin
            if (wrap && pending) begin
                active     <= shadow;
                active_neg <= shadow_neg;
                pending    <= 1'b0;
            end
            if (load) begin
                shadow     <= bcd_in;
                shadow_neg <= neg_in;
                pending    <= 1'b1;
            end
        end
    end

    // Highest nonzero digit position; zero when the value is zero.
    always_comb begin
        msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (active[i*4 +: 4] != 4'd0) begin
                msd = IW'(i);
            end
        end
    end

    assign nonzero   = (active != '0);
    assign neg_show  = active_neg && nonzero;
    assign msd_p1    = msd + IW'(1);
    assign show_dash = neg_show && (msd != LAST_IDX);
    assign cur_nib   = active[idx*4 +: 4];

    bcd_to_seg7 u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // Glyph for the current position: digit, minus sign or blank.
    always_comb begin
        seg_next = dec_seg;
        if ((BLANK_ZEROS != 0) && (idx > msd)) begin
            if (show_dash && (idx == msd_p1)) begin
                seg_next = SEG_DASH;
            end else begin
                seg_next = SEG_OFF;
            end
        end
    end

    // Output register, one cycle behind the index/active state.
    always_ff @(posedge clock) begin
        if (reset) begin
            digit_sel  <= '1;
            seg        <= SEG_OFF;
            neg_led    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            digit_sel  <= ~(ONE_HOT0 << idx);
            seg        <= seg_next;
            neg_led    <= neg_show;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Randomized and directed bench for bcd_display_scan.
// Reference derives scan position from elapsed cycles arithmetically.
module tb_bcd_display_scan;

    localparam int ND  = 8;
    localparam int DIV = 4;
    localparam int FRM = ND * DIV;

    logic          clock = 1'b0;
    logic          reset;
    logic          load;
    logic [31:0]   bcd_in;
    logic          neg_in;
    logic [7:0]    digit_sel;
    logic [6:0]    seg;
    logic          neg_led;
    logic          frame_done;

    int total = 0;
    int bad   = 0;

    // reference state
    int          n;
    logic [31:0] m_shadow;
    logic        m_sneg;
    logic        m_pend;
    logic [31:0] m_act;
    logic        m_aneg;
    logic [7:0]  e_ds;
    logic [6:0]  e_seg;
    logic        e_neg;
    logic        e_fd;

    logic [6:0]  cap [0:7];
    logic [6:0]  tbl [0:15];

    bcd_display_scan #(
        .DIGITS      (ND),
        .SCAN_DIV    (DIV),
        .BLANK_ZEROS (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .bcd_in     (bcd_in),
        .neg_in     (neg_in),
        .digit_sel  (digit_sel),
        .seg        (seg),
        .neg_led    (neg_led),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected glyph at position p for signed BCD value a.
    function automatic logic [6:0] glyph(int p, logic [31:0] a, logic an);
        int m;
        m = 0;
        while (m < ND - 1 && (a >> (4 * (m + 1))) != 0) m++;
        if (p <= m) return tbl[(a >> (4 * p)) & 32'hF];
        if (an && a != 0 && m < ND - 1 && p == m + 1) return 7'h3F;
        return 7'h7F;
    endfunction

    task automatic model_edge(input logic r, input logic l,
                              input logic [31:0] b, input logic ng);
        int  pos;
        logic wr;
        if (r) begin
            n = 0;
            m_shadow = 0; m_sneg = 0; m_pend = 0;
            m_act = 0; m_aneg = 0;
            e_ds = 8'hFF; e_seg = 7'h7F; e_neg = 0; e_fd = 0;
        end else begin
            pos   = (n / DIV) % ND;
            e_ds  = ~(8'd1 << pos);
            e_seg = glyph(pos, m_act, m_aneg);
            e_neg = m_aneg && (m_act != 0);
            wr    = (n % FRM) == FRM - 1;
            e_fd  = wr;
            if (wr && m_pend) begin
                m_act = m_shadow; m_aneg = m_sneg; m_pend = 0;
            end
            if (l) begin
                m_shadow = b; m_sneg = ng; m_pend = 1;
            end
            n++;
        end
    endtask

    task automatic step();
        logic r, l, ng;
        logic [31:0] b;
        r = reset; l = load; b = bcd_in; ng = neg_in;
        @(posedge clock);
        model_edge(r, l, b, ng);
        #1;
        chk("digit_sel", {24'd0, digit_sel}, {24'd0, e_ds});
        chk("seg", {25'd0, seg}, {25'd0, e_seg});
        chk("neg_led", {31'd0, neg_led}, {31'd0, e_neg});
        chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
        for (int i = 0; i < ND; i++) begin
            if (digit_sel == ~(8'd1 << i)) cap[i] = seg;
        end
        @(negedge clock);
    endtask

    task automatic do_load(input logic [31:0] v, input logic ng);
        load = 1; bcd_in = v; neg_in = ng;
        step();
        load = 0;
    endtask

    task automatic wait_frame();
        logic seen;
        seen = 0;
        for (int i = 0; i < FRM + 8 && !seen; i++) begin
            step();
            if (frame_done) seen = 1;
        end
        chk("frame_wait", {31'd0, seen}, 32'd1);
    endtask

    // Commit pending data, then sweep a whole frame into cap[].
    task automatic show_frame();
        wait_frame();
        repeat (FRM + 2) step();
    endtask

    task automatic chk_cap(input string tag, input logic [55:0] exp);
        logic [55:0] e;
        e = exp;
        for (int i = 0; i < ND; i++) begin
            chk(tag, {25'd0, cap[i]}, {25'd0, e[i*7 +: 7]});
        end
    endtask

    initial begin
        logic [31:0] v;
        int nd;
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        reset = 1; load = 0; bcd_in = 0; neg_in = 0;
        repeat (3) step();
        chk("rst_ds", {24'd0, digit_sel}, 32'hFF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        reset = 0;
        step();

        // 123 positive; cap packs digit7..digit0
        do_load(32'h00000123, 0);
        show_frame();
        chk_cap("d123", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
                         7'h79, 7'h24, 7'h30});
        chk("n123", {31'd0, neg_led}, 32'd0);

        do_load(32'h00000045, 1);
        show_frame();
        chk_cap("dm45", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
                         7'h3F, 7'h19, 7'h12});
        chk("nm45", {31'd0, neg_led}, 32'd1);

        do_load(32'h12345678, 1);
        show_frame();
        chk_cap("dfull", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                          7'h02, 7'h78, 7'h00});
        chk("nfull", {31'd0, neg_led}, 32'd1);

        do_load(32'h00000000, 1);
        show_frame();
        chk_cap("dnz", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
                        7'h7F, 7'h7F, 7'h40});
        chk("nnz", {31'd0, neg_led}, 32'd0);

        // load exactly on the wrap edge with nothing pending
        while (n % FRM != FRM - 1) step();
        do_load(32'h00000987, 0);
        repeat (FRM - 2) step();
        chk("wrapload_hold", {25'd0, cap[0]}, 32'h40);
        show_frame();
        chk("wrapload_new", {25'd0, cap[0]}, 32'h78);
        chk("wrapload_d2", {25'd0, cap[2]}, 32'h10);

        do_load(32'h0000A0B1, 0);
        show_frame();
        chk_cap("dbad", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F,
                         7'h40, 7'h3F, 7'h79});

        // reset mid-frame at position 5 with a load pending
        do_load(32'h00000555, 1);
        while ((n / DIV) % ND != 5) step();
        reset = 1;
        step();
        chk("mid_rst_ds", {24'd0, digit_sel}, 32'hFF);
        chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
        reset = 0;
        repeat (2 * FRM + 2) step();
        chk("mid_rst_d0", {25'd0, cap[0]}, 32'h40);
        chk("mid_rst_d1", {25'd0, cap[1]}, 32'h7F);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            load  = ($urandom_range(0, 19) == 0);
            nd = $urandom_range(0, ND);
            v = 0;
            for (int i = 0; i < nd; i++) begin
                if ($urandom_range(0, 15) == 0)
                    v[i*4 +: 4] = 4'($urandom_range(10, 15));
                else
                    v[i*4 +: 4] = 4'($urandom_range(0, 9));
            end
            bcd_in = v;
            neg_in = 1'($urandom_range(0, 1));
            step();
        end
        reset = 0; load = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
